// File: rtl/systema_pio_pkg.sv
// Shared register map and control-bit positions for the debounced PIO.
package systema_pio_pkg;

   typedef enum logic [2:0] {
      ADDR_DATA = 3'd0,
      ADDR_RAW  = 3'd1,
      ADDR_MASK = 3'd2,
      ADDR_EDGE = 3'd3,
      ADDR_RISE = 3'd4,
      ADDR_FALL = 3'd5,
      ADDR_CTRL = 3'd6
   } pio_addr_e;

   localparam int unsigned CTRL_BYPASS_BIT = 0;

endpackage

// File: rtl/systema_pio_db_chan.sv
// One input channel: two-flop synchroniser, debounce counter, accepted
// (stable) level and its one-cycle-delayed copy for edge detection.
module systema_pio_db_chan #(
   parameter int unsigned DB_CYCLES     = 50000,
   parameter int unsigned DB_CNT_W      = 16,
   parameter logic        RESET_VAL_BIT = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   input  logic bypass_i,
   output logic sync_o,
   output logic stable_o,
   output logic stable_prev_o
);

   localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_CYCLES - 1);

   logic                meta_q;
   logic                sync_q;
   logic                stable_q, stable_d;
   logic                prev_q;
   logic [DB_CNT_W-1:0] cnt_q, cnt_d;

   // Accept a new level only after it has differed from the stable level for
   // DB_CYCLES consecutive samples; bypass tracks the synchroniser directly.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (bypass_i) begin
         stable_d = sync_q;
      end else if (sync_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync_q;
         end else begin
            cnt_d = cnt_q + DB_CNT_W'(1);
         end
      end
   end

   // Synchroniser, debounce and edge-history state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q   <= RESET_VAL_BIT;
         sync_q   <= RESET_VAL_BIT;
         stable_q <= RESET_VAL_BIT;
         prev_q   <= RESET_VAL_BIT;
         cnt_q    <= '0;
      end else begin
         meta_q   <= in_i;
         sync_q   <= meta_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         cnt_q    <= cnt_d;
      end
   end

   assign sync_o        = sync_q;
   assign stable_o      = stable_q;
   assign stable_prev_o = prev_q;

endmodule

// File: rtl/systema_pio_debounce_irq.sv
// Avalon-MM input PIO with per-channel debounce, per-bit rise/fall edge
// capture (write-1-to-clear) and a masked level interrupt.
module systema_pio_debounce_irq
   import systema_pio_pkg::*;
#(
   parameter int unsigned      WIDTH     = 2,
   parameter int unsigned      DB_CYCLES = 50000,
   parameter int unsigned      DB_CNT_W  = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync_w, stable_w, prev_w, event_w, w1c_w;
   logic             wr_en;
   logic             unused_wdata;

   logic [WIDTH-1:0] mask_q,   mask_d;
   logic [WIDTH-1:0] edge_q,   edge_d;
   logic [WIDTH-1:0] rise_q,   rise_d;
   logic [WIDTH-1:0] fall_q,   fall_d;
   logic             bypass_q, bypass_d;
   logic [31:0]      rdata_q,  rdata_d;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      systema_pio_db_chan #(
         .DB_CYCLES     (DB_CYCLES),
         .DB_CNT_W      (DB_CNT_W),
         .RESET_VAL_BIT (RESET_VAL[g])
      ) u_chan (
         .clk_i         (clk),
         .rst_ni        (reset_n),
         .in_i          (in_port[g]),
         .bypass_i      (bypass_q),
         .sync_o        (sync_w[g]),
         .stable_o      (stable_w[g]),
         .stable_prev_o (prev_w[g])
      );
   end

   assign wr_en        = chipselect & ~write_n;
   assign event_w      = (stable_w & ~prev_w & rise_q) | (~stable_w & prev_w & fall_q);
   assign w1c_w        = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   // Register writes, edge capture (set has priority over clear) and read mux.
   always_comb begin
      mask_d   = mask_q;
      rise_d   = rise_q;
      fall_d   = fall_q;
      bypass_d = bypass_q;
      edge_d   = (edge_q & ~w1c_w) | event_w;
      rdata_d  = '0;

      if (wr_en) begin
         case (address)
            ADDR_MASK: mask_d   = writedata[WIDTH-1:0];
            ADDR_RISE: rise_d   = writedata[WIDTH-1:0];
            ADDR_FALL: fall_d   = writedata[WIDTH-1:0];
            ADDR_CTRL: bypass_d = writedata[CTRL_BYPASS_BIT];
            default:   ;
         endcase
      end

      case (address)
         ADDR_DATA: rdata_d = 32'(stable_w);
         ADDR_RAW:  rdata_d = 32'(sync_w);
         ADDR_MASK: rdata_d = 32'(mask_q);
         ADDR_EDGE: rdata_d = 32'(edge_q);
         ADDR_RISE: rdata_d = 32'(rise_q);
         ADDR_FALL: rdata_d = 32'(fall_q);
         ADDR_CTRL: rdata_d = 32'(bypass_q);
         default:   rdata_d = '0;
      endcase
   end

   // Control/status registers and registered read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q   <= '0;
         edge_q   <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         bypass_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         mask_q   <= mask_d;
         edge_q   <= edge_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         bypass_q <= bypass_d;
         rdata_q  <= rdata_d;
      end
   end

   assign readdata = rdata_q;
   assign irq      = |(edge_q & mask_q);

endmodule
